// File: rtl/keccak_pkg.sv
// Shared constants, FSM encodings and single-round Keccak-f[1600] helpers for keccak512_sponge.
package keccak_pkg;

    localparam int STATE_W = 1600;
    localparam int RATE    = 576;
    localparam int OUT_W   = 512;
    localparam int STEPS   = 12;

    localparam logic [1:0] ST_IDLE_ABSORB = 2'd0;
    localparam logic [1:0] ST_PERMUTE     = 2'd1;
    localparam logic [1:0] ST_SQUEEZE     = 2'd2;

    // Rho rotation offsets, indexed by lane number 5*y+x
    localparam int RHO_OFF [25] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    function automatic int lane_hi(input int x, input int y);
        return 1599 - 64 * (5 * y + x);
    endfunction

    function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
        return (n == 0) ? v : ((v << n) | (v >> (64 - n)));
    endfunction

    // Only bit positions 2^j-1 of a round constant can be set
    function automatic logic [63:0] rc_expand(input logic [6:0] c);
        logic [63:0] e;
        e     = '0;
        e[0]  = c[0];
        e[1]  = c[1];
        e[3]  = c[2];
        e[7]  = c[3];
        e[15] = c[4];
        e[31] = c[5];
        e[63] = c[6];
        return e;
    endfunction

    function automatic logic [STATE_W-1:0] keccak_round(input logic [STATE_W-1:0] s,
                                                        input logic [63:0] rc);
        logic [63:0] a [25];
        logic [63:0] b [25];
        logic [63:0] c [5];
        logic [63:0] d [5];
        logic [STATE_W-1:0] r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                a[5*y+x] = s[lane_hi(x, y) -: 64];
        for (int x = 0; x < 5; x++)
            c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++)
            d[x] = c[(x+4)%5] ^ rol64(c[(x+1)%5], 1);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                b[y + 5*((2*x + 3*y) % 5)] = rol64(a[5*y+x] ^ d[x], RHO_OFF[5*y+x]);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                a[5*y+x] = b[5*y+x] ^ (~b[5*y + (x+1)%5] & b[5*y + (x+2)%5]);
        a[0] = a[0] ^ rc;
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[lane_hi(x, y) -: 64] = a[5*y+x];
        return r;
    endfunction

endpackage

// File: rtl/keccak_rconst_pair.sv
// Round-constant pair for one two-round step: RC[2*step] and RC[2*step+1],
// read from a compressed 24 x 7-bit table and expanded to 64 bits.
module keccak_rconst_pair
    import keccak_pkg::*;
(
    input  logic [3:0]  i_step,
    output logic [63:0] o_rc1,
    output logic [63:0] o_rc2
);

    localparam logic [6:0] RC_ROM [24] = '{
        7'h01, 7'h1A, 7'h5E, 7'h70, 7'h1F, 7'h21, 7'h79, 7'h55,
        7'h0E, 7'h0C, 7'h35, 7'h26, 7'h3F, 7'h4F, 7'h5D, 7'h53,
        7'h52, 7'h48, 7'h16, 7'h66, 7'h79, 7'h58, 7'h21, 7'h74
    };

    logic [4:0] w_idx1;
    logic [4:0] w_idx2;

    assign w_idx1 = {i_step, 1'b0};
    assign w_idx2 = {i_step, 1'b1};

    // Steps 12..15 never occur; they read as zero rather than out of range
    always_comb begin
        o_rc1 = '0;
        o_rc2 = '0;
        if (i_step < 4'd12) begin
            o_rc1 = rc_expand(RC_ROM[w_idx1]);
            o_rc2 = rc_expand(RC_ROM[w_idx2]);
        end
    end

endmodule

// File: rtl/keccak512_sponge.sv
// SHA3-512 sponge controller: absorbs padded 576-bit blocks, permutes two rounds per cycle.
// Optional macro KECCAK_ABORT_EN adds an abort input that returns the sponge to IDLE.
module keccak512_sponge
    import keccak_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [RATE-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
`ifdef KECCAK_ABORT_EN
    input  logic             abort,
`endif
    output logic             in_ready,
    output logic [OUT_W-1:0] out_hash,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

    logic [STATE_W-1:0] r_state;
    logic [1:0]         r_fsm;
    logic [3:0]         r_step;
    logic               r_last_q;

    logic [63:0]        w_rc1;
    logic [63:0]        w_rc2;
    logic [STATE_W-1:0] w_perm;
    logic               w_abort;

`ifdef KECCAK_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    keccak_rconst_pair u_rconst (
        .i_step (r_step),
        .o_rc1  (w_rc1),
        .o_rc2  (w_rc2)
    );

    assign w_perm    = keccak_round(keccak_round(r_state, w_rc1), w_rc2);
    assign in_ready  = (r_fsm == ST_IDLE_ABSORB);
    assign out_valid = (r_fsm == ST_SQUEEZE);
    assign out_hash  = r_state[STATE_W-1 -: OUT_W];

    // IDLE and ABSORB share one encoding; a non-final block simply leaves the state non-zero
    always_ff @(posedge clk) begin
        if (!reset_n || w_abort) begin
            r_state  <= '0;
            r_fsm    <= ST_IDLE_ABSORB;
            r_step   <= '0;
            r_last_q <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE_ABSORB: begin
                    if (in_valid) begin
                        r_state[STATE_W-1 -: RATE] <= r_state[STATE_W-1 -: RATE] ^ in_data;
                        r_last_q <= in_last;
                        r_step   <= '0;
                        r_fsm    <= ST_PERMUTE;
                    end
                end
                ST_PERMUTE: begin
                    r_state <= w_perm;
                    if (r_step == LAST_STEP) begin
                        r_step <= '0;
                        r_fsm  <= r_last_q ? ST_SQUEEZE : ST_IDLE_ABSORB;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                ST_SQUEEZE: begin
                    if (out_ready) begin
                        r_state  <= '0;
                        r_last_q <= 1'b0;
                        r_fsm    <= ST_IDLE_ABSORB;
                    end
                end
                default: r_fsm <= ST_IDLE_ABSORB;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak512_sponge.sv
// Testbench for keccak512_sponge: table of padded messages checked against a lane-array
// SHA3-512 model, plus hand-written backpressure, back-to-back, reset and abort sequences.
`timescale 1ns/1ps
module tb_keccak512_sponge;

    localparam logic [575:0] EMPTY_BLOCK  = {64'h6, 448'h0, 64'h8000000000000000};
    localparam logic [511:0] EMPTY_DIGEST = {
        64'hc59a3aa2cc739fa6, 64'h6e755a18dc67b5c8, 64'h5958e24f1682c997, 64'ha6805c47c1dcd1e0,
        64'h4cf9f5f13a12b215, 64'h58c53a2c40e9e311, 64'he3d3b6959d1900f5, 64'h26cd1d2886857501
    };
    localparam int NVEC = 8;

    typedef struct {
        logic [2:0][575:0] blk;
        int                nBlocks;
        logic [511:0]      expDigest;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [575:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] out_hash;
    logic         out_valid;
    logic         out_ready;
`ifdef KECCAK_ABORT_EN
    logic         abort;
`endif

    int   nCompared   = 0;
    int   nMismatched = 0;
    int   cycleCount  = 0;
    vec_t vecs [NVEC];

    logic [63:0] mA [5][5];
    int          rotOff [5][5];

    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    keccak512_sponge dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
`ifdef KECCAK_ABORT_EN
        .abort     (abort),
`endif
        .in_ready  (in_ready),
        .out_hash  (out_hash),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        int m;
        m = n % 64;
        return (m == 0) ? v : ((v << m) | (v >> (64 - m)));
    endfunction

    // Round constants from the Keccak LFSR x^8+x^6+x^5+x^4+1
    function automatic logic lfsrBit(input int t);
        logic [8:0] r;
        r = 9'd1;
        for (int i = 0; i < t % 255; i++) begin
            r = r << 1;
            if (r[8]) r = r ^ 9'h171;
        end
        return r[0];
    endfunction

    function automatic logic [63:0] roundConst(input int ir);
        logic [63:0] rc;
        rc = '0;
        for (int j = 0; j < 7; j++) rc[(1 << j) - 1] = lfsrBit(j + 7 * ir);
        return rc;
    endfunction

    task automatic modelInit();
        int x, y, nx;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) rotOff[i][j] = 0;
        x = 1; y = 0;
        for (int t = 0; t < 24; t++) begin
            rotOff[x][y] = ((t + 1) * (t + 2) / 2) % 64;
            nx = y;
            y  = (2 * x + 3 * y) % 5;
            x  = nx;
        end
    endtask

    task automatic modelPermute();
        logic [63:0] c [5];
        logic [63:0] d [5];
        logic [63:0] b [5][5];
        for (int r = 0; r < 24; r++) begin
            for (int x = 0; x < 5; x++) c[x] = mA[x][0] ^ mA[x][1] ^ mA[x][2] ^ mA[x][3] ^ mA[x][4];
            for (int x = 0; x < 5; x++) d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) mA[x][y] = mA[x][y] ^ d[x];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) b[y][(2 * x + 3 * y) % 5] = rotl(mA[x][y], rotOff[x][y]);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    mA[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
            mA[0][0] = mA[0][0] ^ roundConst(r);
        end
    endtask

    task automatic modelHash(input int idx);
        logic [575:0] blkTmp;
        logic [511:0] dig;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) mA[x][y] = '0;
        for (int b = 0; b < vecs[idx].nBlocks; b++) begin
            blkTmp = vecs[idx].blk[b];
            for (int k = 0; k < 9; k++) mA[k % 5][k / 5] = mA[k % 5][k / 5] ^ blkTmp[575 - 64 * k -: 64];
            modelPermute();
        end
        for (int k = 0; k < 8; k++) dig[511 - 64 * k -: 64] = mA[k % 5][k / 5];
        vecs[idx].expDigest = dig;
    endtask

    // Byte-oriented SHA3 padding (0x06 ... 0x80) into lane-ordered rate blocks
    task automatic buildVector(input int idx, input int len, input logic [7:0] fill, input bit useRandom);
        logic [7:0]   pb [216];
        logic [575:0] blkTmp;
        int           n;
        n = len / 72 + 1;
        for (int j = 0; j < 216; j++) pb[j] = (j < len) ? (useRandom ? 8'($urandom) : fill) : 8'h00;
        pb[len]        = pb[len] ^ 8'h06;
        pb[n * 72 - 1] = pb[n * 72 - 1] ^ 8'h80;
        vecs[idx].nBlocks = n;
        vecs[idx].blk     = '0;
        for (int b = 0; b < n; b++) begin
            blkTmp = '0;
            for (int j = 0; j < 72; j++) blkTmp[512 - 64 * (j / 8) + 8 * (j % 8) +: 8] = pb[b * 72 + j];
            vecs[idx].blk[b] = blkTmp;
        end
        modelHash(idx);
    endtask

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block and hold it until accepted; waited counts busy (in_ready=0) cycles
    task automatic applyStimulus(input logic [575:0] blk, input logic last,
                                 output int acceptCycle, output int waited);
        waited   = 0;
        in_data  = blk;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("acceptInReady", 512'(in_ready), 512'd1);
        acceptCycle = cycleCount;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitDigest(output int seenCycle);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("digestValid", 512'(out_valid), 512'd1);
        seenCycle = cycleCount;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("postConsumeOutValid", 512'(out_valid), 512'd0);
        checkOutput("postConsumeInReady", 512'(in_ready), 512'd1);
    endtask

    task automatic runEmpty(input string name);
        int acc, waited, seen;
        applyStimulus(EMPTY_BLOCK, 1'b1, acc, waited);
        waitDigest(seen);
        checkOutput(name, out_hash, EMPTY_DIGEST);
        consume();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, firstAcc, waited, seen, bad, d;
        logic [511:0] held;
        int accQ[$];
        int digQ[$];
        logic [511:0] hashQ[$];

        modelInit();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef KECCAK_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetInReady", 512'(in_ready), 512'd1);
        checkOutput("resetOutValid", 512'(out_valid), 512'd0);
        checkOutput("resetHash", out_hash, 512'd0);
        reset_n = 1'b1;
        tick();

        vecs[0].blk       = '0;
        vecs[0].blk[0]    = EMPTY_BLOCK;
        vecs[0].nBlocks   = 1;
        vecs[0].expDigest = EMPTY_DIGEST;
        buildVector(1, 72, 8'h61, 1'b0);
        for (int i = 2; i < NVEC; i++) buildVector(i, int'($urandom_range(0, 215)), 8'h00, 1'b1);

        $display("[TB] table-driven messages");
        for (int i = 0; i < NVEC; i++) begin
            firstAcc = 0;
            for (int b = 0; b < vecs[i].nBlocks; b++) begin
                applyStimulus(vecs[i].blk[b], (b == vecs[i].nBlocks - 1), acc, waited);
                if (b == 0) firstAcc = acc;
                else checkOutput($sformatf("vec%0d blk%0d busyCycles", i, b), 512'(waited), 512'd12);
            end
            waitDigest(seen);
            checkOutput($sformatf("vec%0d digest", i), out_hash, vecs[i].expDigest);
            checkOutput($sformatf("vec%0d latency", i), 512'(seen - acc), 512'd13);
            checkOutput($sformatf("vec%0d totalLatency", i), 512'(seen - firstAcc), 512'(13 * vecs[i].nBlocks));
            d = int'($urandom_range(0, 3));
            repeat (d) @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d heldValid", i), 512'(out_valid), 512'd1);
            consume();
        end

        $display("[TB] backpressure");
        applyStimulus(EMPTY_BLOCK, 1'b1, acc, waited);
        waitDigest(seen);
        held = out_hash;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_hash !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            if (i < 19) @(negedge clk);
        end
        checkOutput("bpHeldDigest", held, EMPTY_DIGEST);
        checkOutput("bpStableCycles", 512'(bad), 512'd0);
        consume();

        $display("[TB] back-to-back");
        in_data   = EMPTY_BLOCK;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 80 && digQ.size() < 2; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) accQ.push_back(cycleCount);
            if (out_valid) begin
                digQ.push_back(cycleCount);
                hashQ.push_back(out_hash);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checkOutput("b2bDigestCount", 512'(digQ.size()), 512'd2);
        checkOutput("b2bAcceptCount", 512'(accQ.size()), 512'd2);
        if (digQ.size() == 2 && accQ.size() == 2) begin
            checkOutput("b2bDigest0", hashQ[0], EMPTY_DIGEST);
            checkOutput("b2bDigest1", hashQ[1], EMPTY_DIGEST);
            checkOutput("b2bLatency0", 512'(digQ[0] - accQ[0]), 512'd13);
            checkOutput("b2bSecondAccept", 512'(accQ[1] - digQ[0]), 512'd1);
            checkOutput("b2bLatency1", 512'(digQ[1] - accQ[1]), 512'd13);
        end

        $display("[TB] reset mid-permute");
        applyStimulus(EMPTY_BLOCK, 1'b1, acc, waited);
        repeat (5) tick();
        checkOutput("busyBeforeReset", 512'(in_ready), 512'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("midResetInReady", 512'(in_ready), 512'd1);
        checkOutput("midResetOutValid", 512'(out_valid), 512'd0);
        checkOutput("midResetHash", out_hash, 512'd0);
        runEmpty("afterResetDigest");

`ifdef KECCAK_ABORT_EN
        $display("[TB] abort mid-permute");
        applyStimulus(vecs[1].blk[0], 1'b0, acc, waited);
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortInReady", 512'(in_ready), 512'd1);
        checkOutput("abortOutValid", 512'(out_valid), 512'd0);
        checkOutput("abortHash", out_hash, 512'd0);
        runEmpty("afterAbortDigest");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
